// File: rtl/sqrt_pkg.sv
// Shared constants, FSM state type and sizing helper for the sqrt_sched slice.
package sqrt_pkg;

    localparam int SQRT_W    = 21;
    localparam int SQRT_ITER = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sqrt_sched_if.sv
// Request/result handshake bundle between sqrt_sched and its requesters and result sink.
interface sqrt_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 21,
    parameter int IDW  = $clog2(NREQ)
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [W-1:0]      res_y;
    logic [IDW-1:0]    res_id;
    logic              res_ready;
    logic              busy;

    modport master (
        output req_valid, req_x, res_ready,
        input  req_ready, res_valid, res_y, res_id, busy
    );

    modport slave (
        input  req_valid, req_x, res_ready,
        output req_ready, res_valid, res_y, res_id, busy
    );

endinterface

// File: rtl/sqrt_iter_step.sv
// One combinational step of the bit-serial square-root engine: the single squarer and comparator.
module sqrt_iter_step
    import sqrt_pkg::*;
#(
    parameter int W    = SQRT_W,
    parameter int ITER = (W + 1) / 2,
    parameter int CW   = cnt_w(ITER)
) (
    input  logic [ITER-1:0] last,
    input  logic [CW-1:0]   i,
    input  logic [W-1:0]    x,
    output logic [ITER-1:0] next_last
);

    localparam int PW = 2 * ITER;

    logic [ITER-1:0] t;
    logic [PW-1:0]   t_sq;
    logic [PW-1:0]   x_ext;

    // Full-width square so the strict compare never sees a truncated product.
    always_comb begin
        t         = last | (ITER'(1) << i);
        t_sq      = PW'(t) * PW'(t);
        x_ext     = PW'(x);
        next_last = (t_sq < x_ext) ? t : last;
    end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one iterative integer square-root engine among NREQ requesters.
// Define SQRT_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module sqrt_sched
    import sqrt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = SQRT_W,
    parameter int ITER = (W + 1) / 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic         clk,
    input logic         rst,
    sqrt_sched_if.slave bus
);

    localparam int CW = cnt_w(ITER);

    sqrt_state_t     state_q;
    sqrt_state_t     state_d;
    logic [CW-1:0]   i_q;
    logic [ITER-1:0] last_q;
    logic [ITER-1:0] next_last;
    logic [W-1:0]    x_q;
    logic [IDW-1:0]  id_q;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;
    logic            hs;

`ifdef SQRT_SCHED_RR_EN
    logic [IDW-1:0]  rr_ptr;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[(int'(rr_ptr) + 1 + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(rr_ptr) + 1 + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= IDW'(NREQ - 1);
        end else if (hs) begin
            rr_ptr <= gnt_idx;
        end
    end
`else
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(k);
            end
        end
    end
`endif

    // A grant is only ever offered in IDLE, so offering it is the handshake.
    assign hs = (state_q == IDLE) && gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (hs) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs)            state_d = CALC;
            CALC:    if (i_q == '0)     state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                i_q <= CW'(ITER - 1);
            end else if (state_q == CALC && i_q != '0) begin
                i_q <= i_q - CW'(1);
            end
        end
    end

    // Operand, owner and accumulator carry no reset; outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (hs) begin
            x_q    <= bus.req_x[int'(gnt_idx) * W +: W];
            id_q   <= gnt_idx;
            last_q <= '0;
        end else if (state_q == CALC) begin
            last_q <= next_last;
        end
    end

    sqrt_iter_step #(
        .W    (W),
        .ITER (ITER),
        .CW   (CW)
    ) u_step (
        .last      (last_q),
        .i         (i_q),
        .x         (x_q),
        .next_last (next_last)
    );

    // Decodes of registered state only, so an abort clears them asynchronously.
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_y     = bus.res_valid ? W'(last_q) : '0;
    assign bus.res_id    = bus.res_valid ? id_q : '0;

endmodule

// File: doc/sqrt_sched.md
# sqrt_sched

Sequential square-root scheduler that shares one iterative 21-bit integer square-root engine among `NREQ` requesters. It sits between the client blocks that need square roots and a single multiplier/comparator datapath. It arbitrates requests, steps the engine one result bit per cycle, and returns each result tagged with the requester index through a valid/ready handshake.

## Interface
- `NREQ`, default 4: number of requesters; must be 2 or more.
- `W`, default 21: operand and result width.
- `ITER`, default (W+1)/2 = 11: engine iterations, which is also the number of significant result bits.
- `IDW`, default $clog2(NREQ): width of the requester id.

- `clk`, in, 1: single clock, all logic on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, NREQ: request valid, one bit per requester.
- `req_x`, in, NREQ*W: operands, packed; requester k occupies bits [k*W +: W].
- `req_ready`, out, NREQ: one-hot grant, or all zero.
- `res_valid`, out, 1: result valid.
- `res_y`, out, W: result. Bits [W-1:ITER] are always 0.
- `res_id`, out, IDW: index of the requester that owns the result.
- `res_ready`, in, 1: downstream accepts the result.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- **Result definition:** `res_y` is the largest y with y*y < x (strict less-than).
  - x=0 and x=1 give 0; x=16 gives 3; x=17 gives 4.
- **FSM states:** IDLE, CALC, DONE.
- **IDLE:**
  - `req_ready` is high for the granted requester only, and only while its `req_valid` is high.
  - The grant is recomputed combinationally every cycle. A requester may drop `req_valid` before it is granted.
  - Handshake on (`req_valid[g]` & `req_ready[g]`) does the following:
    - latch `req_x[g]` into x_q and g into id_q;
    - clear the accumulator `last`;
    - set bit counter i = ITER-1;
    - move to CALC.
- **CALC:** one bit per cycle.
  - t = last | (1<<i).
  - If t*t < x_q, then `last` = t.
  - If i==0, move to DONE; otherwise decrement i.
- **Arithmetic widths:**
  - The product t*t is computed at 2*ITER bits (22 bits) with no truncation.
  - x_q is zero-extended to 2*ITER bits for the compare.
- **DONE:**
  - `res_valid`=1; `res_y`=`last` zero-extended; `res_id`=id_q.
  - On `res_ready`, move to IDLE.
  - `res_y` and `res_id` are stable while `res_valid` is high and `res_ready` is low.
- **Inputs outside IDLE:**
  - `req_ready` is all zero in CALC and DONE, regardless of `req_valid`.
  - `req_x` is sampled only at the handshake. Later changes do not affect an operation in flight.
- **Round-robin pointer:** `rr_ptr` holds the last granted index. It updates on each accepted handshake.

## Timing
- **Reset values (all outputs):**
  - `req_ready`=0, `res_valid`=0, `res_y`=0, `res_id`=0, `busy`=0.
  - State = IDLE.
  - `rr_ptr`=NREQ-1, so requester 0 wins first.
- **Latency:**
  - Handshake at edge T.
  - CALC occupies edges T+1 .. T+ITER.
  - `res_valid` goes high after edge T+ITER, i.e. 11 cycles after acceptance.
- **Throughput:**
  - If `res_ready` is high at edge D, the block is in IDLE from D.
  - The earliest next handshake is at edge D+1.
  - Minimum request-to-request spacing is ITER+2 = 13 cycles.
- **Simultaneous events:**
  - New `req_valid` while in DONE with `res_ready` high: the request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- **Reset mid-operation:**
  - `rst` in CALC or DONE aborts immediately and asynchronously.
  - The partial result is discarded; no `res_valid` pulse is produced.
- **Output registering:** `busy` and `res_valid` are registered state decodes, not combinational paths from inputs.

## Configuration
- **`SQRT_SCHED_RR_EN` defined:** round-robin arbitration.
  - Search starts at `rr_ptr`+1 modulo NREQ.
  - The first requester found with `req_valid` high wins.
- **`SQRT_SCHED_RR_EN` undefined:** fixed priority.
  - The lowest asserted index always wins.
  - `rr_ptr` is not implemented.

## Structure
- **Package `sqrt_pkg`:**
  - constants `SQRT_W`=21 and `SQRT_ITER`=11;
  - state enum `sqrt_state_t` {IDLE, CALC, DONE}.
- **Sub-module `sqrt_iter_step`:**
  - Combinational, one engine step.
  - Inputs: `last`, bit index `i`, `x`.
  - Output: `next_last`.
  - Contains the single squarer and comparator.
- **Top level:** the scheduler holds the FSM, the arbiter, the registers and the handshake.

## Test plan
- **Single request:** requester 2 with x=2097151 → `res_valid` 11 cycles after the handshake, `res_y`=1448, `res_id`=2.
- **Boundary values:** x=0, 1, 16, 17 → `res_y`=0, 0, 3, 4.
- **Round-robin (`SQRT_SCHED_RR_EN`):**
  - All four `req_valid` held high with x=100, 81, 50, 2.
  - Expected grant order 0,1,2,3,0.
  - Expected results 9, 8, 7, 1.
- **Fixed priority (macro undefined):** the same stimulus → requester 0 granted repeatedly.
- **Back-pressure:**
  - Hold `res_ready`=0 for 20 cycles in DONE → `res_y`/`res_id` stable and `req_ready`=0 throughout.
  - Release `res_ready` → next grant occurs 1 cycle later.
- **Reset mid-CALC:** assert `rst` 5 cycles after the handshake → all outputs 0 immediately, no `res_valid`, and requester 0 is granted first after release.
